// File: rtl/mil1553_encoder_if.sv
// Bundle of the word-input handshake and transceiver drive pins of the 1553 encoder.
// master: word source side (drives tdata/tuser/tvalid, observes ready and pins).
// slave : encoder side (consumes the word stream, drives ready and the transceiver pins).
interface mil1553_encoder_if;
    logic [15:0] s_axis_tdata;   // data word, MSB transmitted first
    logic        s_axis_tuser;   // 1 = command/status sync, 0 = data sync
    logic        s_axis_tvalid;  // word available
    logic        s_axis_tready;  // encoder accepts a word this cycle
    logic        diff_p;         // positive bus drive (pmod pin 3)
    logic        diff_n;         // negative bus drive (pmod pin 4)
    logic        tx_en;          // transceiver transmit enable (pmod pin 5)

    modport master (
        output s_axis_tdata,
        output s_axis_tuser,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  diff_p,
        input  diff_n,
        input  tx_en
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tuser,
        input  s_axis_tvalid,
        output s_axis_tready,
        output diff_p,
        output diff_n,
        output tx_en
    );
endinterface

// File: rtl/mil1553_encoder.sv
// Purpose: MIL-STD-1553 Manchester II transmit encoder: sync + 16 data bits + odd parity at 1 Mbit/s.
// Latency: word accepted at edge T drives its first sync level from T+1; word lasts 40*HALF clocks.
// Backpressure: s_axis_tready is high in IDLE and for the single last clock of PARITY, low otherwise.
//
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset; clears outputs immediately, discards any partial word
//   bus    - slave modport: s_axis_tdata/tuser/tvalid in, s_axis_tready out,
//            diff_p/diff_n/tx_en transceiver drive out (all registered)
module mil1553_encoder #(
    parameter int CLOCK_SPEED = 100000000
) (
    input  logic               clk,
    input  logic               resetn,
    mil1553_encoder_if.slave   bus
);

    // Clocks per half-bit (500 ns at 1 Mbit/s).
    localparam int HALF  = CLOCK_SPEED / 2000000;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int IDX_W = 6;  // half-bit index 0..39

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_SYNC_MID  = IDX_W'(3);   // sync level flips here
    localparam logic [IDX_W-1:0] IDX_SYNC_LAST = IDX_W'(5);
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(37);
    localparam logic [IDX_W-1:0] IDX_WORD_LAST = IDX_W'(39);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PARITY
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [16:0]      r_shift;   // {data[15:0], parity}; bit 16 is the bit on the wire
    logic             r_cmd;     // latched sync type
    logic             r_rdy;
    logic             r_diff_p;
    logic             r_diff_n;
    logic             r_tx_en;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [16:0]      w_shift_nxt;
    logic             w_cmd_nxt;
    logic             w_rdy_nxt;
    logic             w_level_nxt;
    logic             w_tx_nxt;
    logic             w_accept;
    logic             w_half_end;
    logic [16:0]      w_load_word;

    assign w_accept    = bus.s_axis_tvalid & r_rdy;
    assign w_half_end  = (r_cnt == CNT_LAST);
    assign w_load_word = {bus.s_axis_tdata, ~^bus.s_axis_tdata};

    // State register and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_cmd    <= 1'b0;
            r_rdy    <= 1'b0;
            r_diff_p <= 1'b0;
            r_diff_n <= 1'b0;
            r_tx_en  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_cmd    <= w_cmd_nxt;
            r_rdy    <= w_rdy_nxt;
            r_diff_p <= w_level_nxt;
            r_diff_n <= w_tx_nxt & ~w_level_nxt;
            r_tx_en  <= w_tx_nxt;
        end
    end

    // Next-state and next-output logic. Outputs are computed from the
    // next-state values so that the registered pins line up exactly with
    // the half-bit boundaries (no one-cycle skew between state and pins).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_cmd_nxt   = r_cmd;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SYNC;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_shift_nxt = w_load_word;
                    w_cmd_nxt   = bus.s_axis_tuser;
                end
            end
            default: begin
                if (!w_half_end) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + IDX_W'(1);
                    case (r_state)
                        S_SYNC: begin
                            if (r_idx == IDX_SYNC_LAST) begin
                                w_state_nxt = S_DATA;
                            end
                        end
                        S_DATA: begin
                            // Data starts on an even index, so odd index = second half of a bit.
                            if (r_idx[0]) begin
                                w_shift_nxt = {r_shift[15:0], 1'b0};
                            end
                            if (r_idx == IDX_DATA_LAST) begin
                                w_state_nxt = S_PARITY;
                            end
                        end
                        default: begin
                            if (r_idx == IDX_WORD_LAST) begin
                                w_idx_nxt = '0;
                                if (w_accept) begin
                                    // Back-to-back: next sync follows with no gap.
                                    w_state_nxt = S_SYNC;
                                    w_shift_nxt = w_load_word;
                                    w_cmd_nxt   = bus.s_axis_tuser;
                                end else begin
                                    w_state_nxt = S_IDLE;
                                end
                            end
                        end
                    endcase
                end
            end
        endcase

        // Line level for the cycle following this edge.
        w_level_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE: w_level_nxt = 1'b0;
            S_SYNC: w_level_nxt = w_cmd_nxt ? (w_idx_nxt < IDX_SYNC_MID)
                                            : (w_idx_nxt >= IDX_SYNC_MID);
            // Manchester II: first half carries the bit, second half its complement.
            default: w_level_nxt = w_idx_nxt[0] ? ~w_shift_nxt[16] : w_shift_nxt[16];
        endcase

        w_tx_nxt  = (w_state_nxt != S_IDLE);

        // Ready is a registered decode of where the FSM will be, so it never
        // depends combinationally on tvalid and is low while in reset.
        w_rdy_nxt = (w_state_nxt == S_IDLE) ||
                    ((w_state_nxt == S_PARITY) &&
                     (w_idx_nxt == IDX_WORD_LAST) &&
                     (w_cnt_nxt == CNT_LAST));
    end

    assign bus.s_axis_tready = r_rdy;
    assign bus.diff_p        = r_diff_p;
    assign bus.diff_n        = r_diff_n;
    assign bus.tx_en         = r_tx_en;

endmodule

// File: tb/tb_mil1553_encoder.sv
`timescale 1ns/1ps
module tb_mil1553_encoder;

    localparam int HALF = 50;
    localparam int WORD = 40 * HALF;

    logic clk;
    logic resetn;

    mil1553_encoder_if bus();

    mil1553_encoder #(.CLOCK_SPEED(100000000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected half-bit sequence, bit 39 first on the wire.
    function automatic logic [39:0] mk_pat(input logic [15:0] d, input logic u, input logic p);
        logic [39:0] r;
        logic [5:0]  sync_cmd;
        logic [5:0]  sync_dat;
        sync_cmd = 6'b111000;
        sync_dat = 6'b000111;
        r = '0;
        r[39:34] = u ? sync_cmd : sync_dat;
        for (int i = 0; i < 16; i++) begin
            r[33-2*i] = d[15-i];
            r[32-2*i] = ~d[15-i];
        end
        r[1] = p;
        r[0] = ~p;
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int          mcnt = 0;
    int          words_done = 0;
    int          idle_err = 0;
    int          jit, nerr, rdyc, rdy_pos, h, ph;
    logic [39:0] cur_exp, obs;

    always @(negedge clk) begin
        if (!resetn) begin
            mcnt = 0;
        end else if (bus.tx_en) begin
            if (mcnt == 0) begin
                chk("word_expected", 64'(exp_q.size() > 0), 64'(1));
                cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                obs = '0; jit = 0; nerr = 0; rdyc = 0; rdy_pos = -1;
            end
            h  = mcnt / HALF;
            ph = mcnt % HALF;
            if (bus.diff_p !== cur_exp[39-h]) jit++;
            if (ph == HALF/2) obs[39-h] = bus.diff_p;
            if (bus.diff_n !== ~bus.diff_p) nerr++;
            if (bus.s_axis_tready) begin
                rdyc++;
                rdy_pos = mcnt;
            end
            mcnt++;
            if (mcnt == WORD) begin
                chk("pattern",      64'(obs),     64'(cur_exp));
                chk("half_stable",  64'(jit),     64'(0));
                chk("diff_n_compl", 64'(nerr),    64'(0));
                chk("rdy_count",    64'(rdyc),    64'(1));
                chk("rdy_position", 64'(rdy_pos), 64'(WORD-1));
                words_done++;
                mcnt = 0;
            end
        end else begin
            if (mcnt != 0) begin
                chk("tx_en_early_drop", 64'(mcnt), 64'(WORD));
                mcnt = 0;
            end
            if (bus.diff_p || bus.diff_n) idle_err++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [15:0] d, input logic u, input logic p,
                        input bit keep, output int waited);
        bus.s_axis_tdata  = d;
        bus.s_axis_tuser  = u;
        bus.s_axis_tvalid = 1'b1;
        waited = 0;
        while (!bus.s_axis_tready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.s_axis_tready) begin
            chk("accept_timeout", 64'(waited), 64'(0));
            bus.s_axis_tvalid = 1'b0;
            return;
        end
        exp_q.push_back(mk_pat(d, u, p));
        @(negedge clk);
        // First sync level visible right after the accepting edge.
        chk($sformatf("first_level_%h", d), 64'({bus.tx_en, bus.diff_p}), 64'({1'b1, u}));
        if (!keep) bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.tx_en && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_len", 64'(n), 64'(WORD));
    endtask

    initial begin
        int w;
        int rst_err;
        int resid;
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int rst_err;
        int resid;
        resetn = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tvalid = 1'b0;

        rst_err = 0;
        repeat (10) begin
            @(negedge clk);
            if ({bus.s_axis_tready, bus.diff_p, bus.diff_n, bus.tx_en} !== 4'b0000) rst_err++;
        end
        chk("reset_outputs", 64'(rst_err), 64'(0));

        #2 resetn = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", 64'(bus.s_axis_tready), 64'(1));
        chk("idle_after_reset", 64'({bus.diff_p, bus.diff_n, bus.tx_en}), 64'(0));
        repeat (20) @(negedge clk);

        // Single words
        send(16'h0000, 1'b1, 1'b1, 1'b0, w); wait_idle();
        send(16'h8001, 1'b0, 1'b1, 1'b0, w); wait_idle();
        send(16'h0001, 1'b0, 1'b0, 1'b0, w); wait_idle();
        repeat (5) @(negedge clk);

        // Back-to-back with tvalid held high
        send(16'h1234, 1'b1, 1'b0, 1'b1, w);
        bus.s_axis_tdata = 16'hABCD;
        bus.s_axis_tuser = 1'b0;
        send(16'hABCD, 1'b0, 1'b1, 1'b0, w);
        chk("b2b_wait", 64'(w), 64'(WORD-1));
        chk("b2b_rdy_drop", 64'(bus.s_axis_tready), 64'(0));
        wait_idle();
        repeat (5) @(negedge clk);

        // Reset in the middle of a word
        send(16'h00FF, 1'b1, 1'b1, 1'b0, w);
        repeat (699) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({bus.s_axis_tready, bus.diff_p, bus.diff_n, bus.tx_en}), 64'(0));
        exp_q.delete();
        repeat (5) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        chk("rdy_after_midreset", 64'(bus.s_axis_tready), 64'(1));
        resid = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx_en || bus.diff_p || bus.diff_n) resid++;
        end
        chk("no_residual_tx", 64'(resid), 64'(0));
        send(16'h5A5A, 1'b1, 1'b1, 1'b0, w); wait_idle();
        repeat (10) @(negedge clk);

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        chk("words_done",    64'(words_done),   64'(6));
        chk("idle_quiet",    64'(idle_err),     64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
